// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//   - uart_state_e      : receiver frame state
//   - UART_DATA_BITS    : data bits per frame
//   - UART_OVERSAMPLE   : oversample ticks per bit
//   - MID_START_IDX / MID_BIT_IDX : os_cnt values at which the line is sampled
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    // Start bit is checked half a bit in; data/stop are sampled one full bit later each.
    localparam logic [3:0] MID_START_IDX = 4'd7;
    localparam logic [3:0] MID_BIT_IDX   = 4'd15;
    localparam logic [2:0] LAST_BIT_IDX  = 3'(UART_DATA_BITS - 1);

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divider producing the oversample tick.
// Ports:
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse every TICK_DIV cycles (high when count = TICK_DIV-1)
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int TICK_DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);
    // tick is registered, so it is raised one count early to line up with CNT_LAST.
    localparam logic [15:0] CNT_PRE  = 16'(TICK_DIV - 2);

    logic [15:0] cnt_r;

    // Divider counter and registered tick strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
            tick  <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
            tick <= (cnt_r == CNT_PRE);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 16x oversampling, one-entry output buffer.
// Ports:
//   clk       : system clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   rx        : asynchronous serial line, idles high
//   rx_data   : received byte, valid while rx_valid is high
//   rx_valid  : buffered byte available
//   rx_ready  : consumer accepts the byte when rx_valid is high
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : one-cycle pulse when a good byte is dropped because the buffer is full
module uart_rx
    import uart_pkg::*;
#(
    parameter int TICK_DIV = 651
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    logic        rx_meta_r;
    logic        rx_s_r;
    logic        tick_s;
    uart_state_e state_r;
    logic [3:0]  os_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;

    uart_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // Two-flop synchronizer for the asynchronous serial line; resets to idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
        end
    end

    // Frame state machine, shift register, output buffer and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            os_cnt_r  <= 4'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer handshake; a delivery below in the same cycle re-asserts valid.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (tick_s) begin
                case (state_r)
                    IDLE: begin
                        if (!rx_s_r) begin
                            state_r  <= START;
                            os_cnt_r <= 4'd0;
                        end
                    end
                    START: begin
                        os_cnt_r <= os_cnt_r + 4'd1;
                        if (os_cnt_r == MID_START_IDX) begin
                            if (!rx_s_r) begin
                                state_r   <= DATA;
                                os_cnt_r  <= 4'd0;
                                bit_cnt_r <= 3'd0;
                            end else begin
                                // Line went back high before mid start bit: glitch.
                                state_r <= IDLE;
                            end
                        end
                    end
                    DATA: begin
                        os_cnt_r <= os_cnt_r + 4'd1;
                        if (os_cnt_r == MID_BIT_IDX) begin
                            // LSB arrives first, so each new bit enters at the top.
                            shift_r   <= {rx_s_r, shift_r[7:1]};
                            os_cnt_r  <= 4'd0;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == LAST_BIT_IDX) begin
                                state_r <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        os_cnt_r <= os_cnt_r + 4'd1;
                        if (os_cnt_r == MID_BIT_IDX) begin
                            state_r <= IDLE;
                            if (rx_s_r) begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift_r;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
